lsu_ctrl: RTL and testbench

//  Load/store execution unit that sits directly downstream of the load/store decoder (RV64 LOAD/STORE ops).

---
 rtl/lsu_pkg.sv | 70 +++++++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store execution unit: FSM states, op flag
// positions, access sizes, exception causes and small decode helpers.
package lsu_pkg;

    localparam int LSU_XLEN   = 64;
    localparam int LSU_ADDR_W = 32;
    localparam int NUM_OPS    = 11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_EXC  = 3'd4
    } state_e;

    localparam int OP_LB  = 0;
    localparam int OP_LH  = 1;
    localparam int OP_LW  = 2;
    localparam int OP_LBU = 3;
    localparam int OP_LHU = 4;
    localparam int OP_LWU = 5;
    localparam int OP_LD  = 6;
    localparam int OP_SB  = 7;
    localparam int OP_SH  = 8;
    localparam int OP_SW  = 9;
    localparam int OP_SD  = 10;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

    // More than one flag set: clearing the lowest set bit leaves something.
    function automatic logic multi_flag(input logic [NUM_OPS-1:0] f);
        return (f & (f - 11'd1)) != 11'd0;
    endfunction

    function automatic logic [1:0] flags_size(input logic [NUM_OPS-1:0] f);
        logic [1:0] sz;
        if (f[OP_LB] || f[OP_LBU] || f[OP_SB]) begin
            sz = SZ_B;
        end else if (f[OP_LH] || f[OP_LHU] || f[OP_SH]) begin
            sz = SZ_H;
        end else if (f[OP_LW] || f[OP_LWU] || f[OP_SW]) begin
            sz = SZ_W;
        end else begin
            sz = SZ_D;
        end
        return sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            SZ_D:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for one doubleword bus: store byte enables and data shift,
// and load extraction with sign or zero extension.
module lsu_align import lsu_pkg::*; #(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [1:0]      size,
    input  logic [2:0]      off,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_data,
    output logic [7:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_result
);

    logic [XLEN-1:0] x_s;

    // Lane shift both ways, then pick width and extension by access size
    always_comb begin
        x_s       = ld_data >> {off, 3'b000};
        wdata     = st_data << {off, 3'b000};
        be        = 8'h00;
        ld_result = {XLEN{1'b0}};
        case (size)
            SZ_B: begin
                be        = 8'h01 << off;
                ld_result = {{(XLEN-8){x_s[7] & ~is_unsigned}}, x_s[7:0]};
            end
            SZ_H: begin
                be        = 8'h03 << off;
                ld_result = {{(XLEN-16){x_s[15] & ~is_unsigned}}, x_s[15:0]};
            end
            SZ_W: begin
                be        = 8'h0F << off;
                ld_result = {{(XLEN-32){x_s[31] & ~is_unsigned}}, x_s[31:0]};
            end
            SZ_D: begin
                be        = 8'hFF;
                ld_result = x_s;
            end
            default: begin
                be        = 8'h00;
                ld_result = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store execution unit: one decoded memory op at a time, address generation,
// alignment check, valid/ready memory request and load writeback.
module lsu_ctrl import lsu_pkg::*; #(
    parameter int XLEN   = LSU_XLEN,
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [10:0]       op_flags,
    input  logic [4:0]        rd,
    input  logic [11:0]       imm,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] fault_addr
);

    state_e            state_r, state_nxt_s;
    logic              accept_s, illegal_s, misalign_s, store_s, unsigned_s;
    logic [1:0]        size_s, size_r, al_size_s;
    logic [2:0]        off_r, al_off_s;
    logic              unsigned_r, al_uns_s;
    logic [4:0]        rd_r;
    logic [ADDR_W-1:0] ea_s;
    logic [7:0]        be_s;
    logic [XLEN-1:0]   st_shift_s, ld_fmt_s;
    logic              unused_s;

    assign dec_ready = (state_r == ST_IDLE);
    assign unused_s  = ^rs1_val[XLEN-1:ADDR_W];

    // Address generation and op decode from the decoder inputs
    always_comb begin
        ea_s       = rs1_val[ADDR_W-1:0] + {{(ADDR_W-12){imm[11]}}, imm};
        accept_s   = dec_valid && dec_ready && (op_flags != 11'd0);
        illegal_s  = multi_flag(op_flags);
        size_s     = flags_size(op_flags);
        misalign_s = misaligned(size_s, ea_s[2:0]);
        store_s    = |op_flags[OP_SD:OP_SB];
        unsigned_s = op_flags[OP_LBU] | op_flags[OP_LHU] | op_flags[OP_LWU];
    end

    // Stores are steered at accept time; loads are formatted later from the latched op
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_size_s = size_s;
            al_off_s  = ea_s[2:0];
            al_uns_s  = unsigned_s;
        end else begin
            al_size_s = size_r;
            al_off_s  = off_r;
            al_uns_s  = unsigned_r;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .size        (al_size_s),
        .off         (al_off_s),
        .is_unsigned (al_uns_s),
        .st_data     (rs2_val),
        .ld_data     (mem_rdata),
        .be          (be_s),
        .wdata       (st_shift_s),
        .ld_result   (ld_fmt_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (illegal_s || misalign_s) ? ST_EXC : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = mem_we ? ST_IDLE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            ST_EXC:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Registered outputs and per-op latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= {ADDR_W{1'b0}};
            mem_be        <= 8'h00;
            mem_wdata     <= {XLEN{1'b0}};
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= {XLEN{1'b0}};
            exc_valid     <= 1'b0;
            exc_cause     <= 2'b00;
            fault_addr    <= {ADDR_W{1'b0}};
            rd_r          <= 5'd0;
            size_r        <= 2'b00;
            off_r         <= 3'd0;
            unsigned_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rd_r       <= rd;
                        size_r     <= size_s;
                        off_r      <= ea_s[2:0];
                        unsigned_r <= unsigned_s;
                        if (illegal_s || misalign_s) begin
                            exc_valid  <= 1'b1;
                            exc_cause  <= illegal_s ? EXC_ILLEGAL : EXC_MISALIGN;
                            fault_addr <= ea_s;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= store_s;
                            mem_addr      <= {ea_s[ADDR_W-1:3], 3'b000};
                            mem_be        <= be_s;
                            mem_wdata     <= st_shift_s;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= (rd_r != 5'd0);
                        wb_rd    <= rd_r;
                        wb_data  <= ld_fmt_s;
                    end
                end
                ST_WB:  wb_valid  <= 1'b0;
                ST_EXC: exc_valid <= 1'b0;
                default: begin
                    mem_req_valid <= 1'b0;
                    wb_valid      <= 1'b0;
                    exc_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset/corner sequences and
// randomized ops checked against a byte-level reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_ready;
    logic [10:0] op_flags;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [63:0] rs1_val, rs2_val;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .op_flags(op_flags), .rd(rd), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .fault_addr(fault_addr)
    );

    typedef struct {
        logic [10:0] flags;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [63:0] rs1, rs2, rdata;
        int          rdy_dly, rv_dly;
        logic        x_req, x_we, x_wbv;
        logic [31:0] x_addr, x_fault;
        logic [7:0]  x_be;
        logic [63:0] x_wdata, x_wb;
        logic [1:0]  x_cause;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [10:0] f, input logic [4:0] r, input logic [11:0] i,
                                 input logic [63:0] a, input logic [63:0] s, input logic [63:0] d,
                                 input int rdy, input int rv);
        vec_t v;
        v.flags = f; v.rd = r; v.imm = i; v.rs1 = a; v.rs2 = s; v.rdata = d;
        v.rdy_dly = rdy; v.rv_dly = rv;
        v.x_req = 1'b0; v.x_we = 1'b0; v.x_wbv = 1'b0; v.x_addr = 32'h0; v.x_fault = 32'h0;
        v.x_be = 8'h00; v.x_wdata = 64'h0; v.x_wb = 64'h0; v.x_cause = 2'b00;
        return v;
    endfunction

    function automatic vec_t expv(input vec_t v, input logic req, input logic we, input logic [31:0] addr,
                                  input logic [7:0] be, input logic [63:0] wd, input logic [1:0] cause,
                                  input logic [31:0] fa, input logic wbv, input logic [63:0] wb);
        vec_t r = v;
        r.x_req = req; r.x_we = we; r.x_addr = addr; r.x_be = be; r.x_wdata = wd;
        r.x_cause = cause; r.x_fault = fa; r.x_wbv = wbv; r.x_wb = wb;
        return r;
    endfunction

    // Access width in bytes for flag position idx ({sd,sw,sh,sb,ld,lwu,lhu,lbu,lw,lh,lb})
    function automatic int nbytes(input int idx);
        case (idx)
            0, 3, 7: return 1;
            1, 4, 8: return 2;
            2, 5, 9: return 4;
            default: return 8;
        endcase
    endfunction

    // Reference model: memory semantics expressed per byte
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] ea;
        logic [63:0] val;
        int idx, n, off, bm;
        r = expv(v, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b00, 32'h0, 1'b0, 64'h0);
        ea = 32'(v.rs1 + {{52{v.imm[11]}}, v.imm});
        if (v.flags == 11'h000) return r;
        if ($countones(v.flags) > 1) begin
            r.x_cause = 2'b10; r.x_fault = ea;
            return r;
        end
        idx = 0;
        for (int i = 0; i < 11; i++) if (v.flags[i]) idx = i;
        n = nbytes(idx);
        off = int'(ea % 32'd8);
        if (ea % 32'(n) != 32'd0) begin
            r.x_cause = 2'b01; r.x_fault = ea;
            return r;
        end
        bm = ((1 << n) - 1) << off;
        r.x_req = 1'b1;
        r.x_we = (idx >= 7);
        r.x_addr = ea - 32'(off);
        r.x_be = bm[7:0];
        if (idx >= 7) begin
            for (int i = 0; i < n; i++) r.x_wdata[8*(off+i) +: 8] = v.rs2[8*i +: 8];
        end else begin
            val = 64'h0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = v.rdata[8*(off+i) +: 8];
            if (idx <= 2 && val[8*n-1]) begin
                for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
            end
            r.x_wbv = (v.rd != 5'd0);
            r.x_wb = val;
        end
        return r;
    endfunction

    // Issue one op, act as memory, observe until the unit is idle again, then compare
    task automatic run_vec(input vec_t v, input string nm);
        logic seen_req = 1'b0, unstable = 1'b0, hs_armed = 1'b0, hs_done = 1'b0, rv_sent = 1'b0, done = 1'b0;
        int exc_n = 0, wb_n = 0, wb_lat = 0, req_n = 0, wait_n = 0;
        logic [1:0] c_cause = 2'b00;
        logic [31:0] c_fault = 32'h0, c_addr = 32'h0;
        logic [7:0] c_be = 8'h00;
        logic c_we = 1'b0;
        logic [63:0] c_wdata = 64'h0, c_wb = 64'h0, mask = 64'h0;
        logic [4:0] c_rd = 5'd0;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        check({nm, " dec_ready_idle"}, {63'h0, dec_ready}, 64'h1);
        dec_valid = 1'b1; op_flags = v.flags; rd = v.rd; imm = v.imm; rs1_val = v.rs1; rs2_val = v.rs2;
        @(posedge clk);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            dec_valid = 1'b0;
            op_flags = 11'($urandom); rd = 5'($urandom); rs1_val = {$urandom, $urandom}; rs2_val = {$urandom, $urandom};
            mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            if (hs_armed) begin hs_done = 1'b1; hs_armed = 1'b0; end
            if (dec_ready) begin
                done = 1'b1;
            end else begin
                if (exc_valid) begin exc_n++; c_cause = exc_cause; c_fault = fault_addr; end
                if (wb_valid) begin wb_n++; wb_lat = cyc; c_wb = wb_data; c_rd = wb_rd; end
                if (mem_req_valid) begin
                    if (!seen_req) begin
                        c_we = mem_we; c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata;
                    end else if ({c_we, c_addr, c_be, c_wdata} !== {mem_we, mem_addr, mem_be, mem_wdata}) begin
                        unstable = 1'b1;
                    end
                    seen_req = 1'b1;
                    if (req_n >= v.rdy_dly) begin mem_req_ready = 1'b1; hs_armed = 1'b1; end
                    req_n++;
                end else if (hs_done && !rv_sent && !c_we) begin
                    if (wait_n >= v.rv_dly) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; rv_sent = 1'b1; end
                    wait_n++;
                end
            end
        end
        check({nm, " completes"}, {63'h0, done}, 64'h1);
        check({nm, " quiet_at_idle"}, {61'h0, mem_req_valid, wb_valid, exc_valid}, 64'h0);
        check({nm, " exc_count"}, 64'(exc_n), (v.x_cause != 2'b00) ? 64'h1 : 64'h0);
        if (v.x_cause != 2'b00) begin
            check({nm, " exc_cause"}, {62'h0, c_cause}, {62'h0, v.x_cause});
            check({nm, " fault_addr"}, {32'h0, c_fault}, {32'h0, v.x_fault});
        end
        check({nm, " req_seen"}, {63'h0, seen_req}, {63'h0, v.x_req});
        if (v.x_req) begin
            check({nm, " mem_we"}, {63'h0, c_we}, {63'h0, v.x_we});
            check({nm, " mem_addr"}, {32'h0, c_addr}, {32'h0, v.x_addr});
            check({nm, " mem_be"}, {56'h0, c_be}, {56'h0, v.x_be});
            check({nm, " req_stable"}, {63'h0, unstable}, 64'h0);
            if (v.x_we) begin
                for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{v.x_be[i]}};
                check({nm, " mem_wdata"}, c_wdata & mask, v.x_wdata & mask);
            end
        end
        check({nm, " wb_count"}, 64'(wb_n), v.x_wbv ? 64'h1 : 64'h0);
        if (v.x_wbv) begin
            check({nm, " wb_data"}, c_wb, v.x_wb);
            check({nm, " wb_rd"}, {59'h0, c_rd}, {59'h0, v.rd});
            if (v.rdy_dly == 0 && v.rv_dly == 0) check({nm, " wb_latency"}, 64'(wb_lat), 64'd3);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctl_zero"}, {57'h0, mem_req_valid, mem_we, wb_valid, exc_valid, exc_cause, 1'b0}, 64'h0);
        check({nm, " addr_zero"}, {mem_addr, fault_addr}, 64'h0);
        check({nm, " data_zero"}, mem_wdata | wb_data | {51'h0, wb_rd, mem_be}, 64'h0);
        check({nm, " dec_ready"}, {63'h0, dec_ready}, 64'h1);
    endtask

    vec_t tbl[15];

    initial begin
        logic saw_wb;
        rst_n = 1'b0; dec_valid = 1'b0; op_flags = 11'h0; rd = 5'd0; imm = 12'h0;
        rs1_val = 64'h0; rs2_val = 64'h0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = expv(mkv(11'h004, 5'd5, 12'h004, 64'h1000, 64'h0, 64'h80000001_12345678, 0, 0),
                       1'b1, 1'b0, 32'h1000, 8'hF0, 64'h0, 2'b00, 32'h0, 1'b1, 64'hFFFFFFFF_80000001);
        tbl[1]  = expv(mkv(11'h001, 5'd6, 12'hFFF, 64'h1008, 64'h0, 64'hF0112233_44556677, 0, 0),
                       1'b1, 1'b0, 32'h1000, 8'h80, 64'h0, 2'b00, 32'h0, 1'b1, 64'hFFFFFFFF_FFFFFFF0);
        tbl[2]  = expv(mkv(11'h008, 5'd6, 12'hFFF, 64'h1008, 64'h0, 64'hF0112233_44556677, 0, 0),
                       1'b1, 1'b0, 32'h1000, 8'h80, 64'h0, 2'b00, 32'h0, 1'b1, 64'h00000000_000000F0);
        tbl[3]  = expv(mkv(11'h100, 5'd0, 12'h002, 64'h2000, 64'hBEEF, 64'h0, 3, 0),
                       1'b1, 1'b1, 32'h2000, 8'h0C, 64'h00000000_BEEF0000, 2'b00, 32'h0, 1'b0, 64'h0);
        tbl[4]  = expv(mkv(11'h200, 5'd1, 12'h006, 64'h2000, 64'h1234, 64'h0, 0, 0),
                       1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b01, 32'h2006, 1'b0, 64'h0);
        tbl[5]  = expv(mkv(11'h003, 5'd2, 12'h011, 64'h3000, 64'h0, 64'h0, 0, 0),
                       1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b10, 32'h3011, 1'b0, 64'h0);
        tbl[6]  = expv(mkv(11'h000, 5'd3, 12'h000, 64'h3000, 64'h0, 64'h0, 0, 0),
                       1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b00, 32'h0, 1'b0, 64'h0);
        tbl[7]  = expv(mkv(11'h040, 5'd0, 12'h008, 64'h4000, 64'h0, 64'h01234567_89ABCDEF, 0, 1),
                       1'b1, 1'b0, 32'h4008, 8'hFF, 64'h0, 2'b00, 32'h0, 1'b0, 64'h0);
        tbl[8]  = expv(mkv(11'h010, 5'd9, 12'h00E, 64'h1000, 64'h0, 64'h80010000_00000000, 1, 0),
                       1'b1, 1'b0, 32'h1008, 8'hC0, 64'h0, 2'b00, 32'h0, 1'b1, 64'h00000000_00008001);
        tbl[9]  = expv(mkv(11'h002, 5'd1, 12'h003, 64'h1000, 64'h0, 64'h0, 0, 0),
                       1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b01, 32'h1003, 1'b0, 64'h0);
        tbl[10] = expv(mkv(11'h040, 5'd1, 12'h004, 64'h1000, 64'h0, 64'h0, 0, 0),
                       1'b0, 1'b0, 32'h0, 8'h00, 64'h0, 2'b01, 32'h1004, 1'b0, 64'h0);
        tbl[11] = expv(mkv(11'h400, 5'd0, 12'h000, 64'h5000, 64'h11223344_55667788, 64'h0, 2, 0),
                       1'b1, 1'b1, 32'h5000, 8'hFF, 64'h11223344_55667788, 2'b00, 32'h0, 1'b0, 64'h0);
        tbl[12] = expv(mkv(11'h080, 5'd0, 12'h005, 64'h5000, 64'hAB, 64'h0, 0, 0),
                       1'b1, 1'b1, 32'h5000, 8'h20, 64'h0000AB00_00000000, 2'b00, 32'h0, 1'b0, 64'h0);
        tbl[13] = expv(mkv(11'h020, 5'd31, 12'h000, 64'h1000, 64'h0, 64'h12345678_FFFFFFFE, 0, 2),
                       1'b1, 1'b0, 32'h1000, 8'h0F, 64'h0, 2'b00, 32'h0, 1'b1, 64'h00000000_FFFFFFFE);
        tbl[14] = expv(mkv(11'h004, 5'd4, 12'h004, 64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'h00000000_7FFFFFFF, 0, 0),
                       1'b1, 1'b0, 32'h0000, 8'h0F, 64'h0, 2'b00, 32'h0, 1'b1, 64'h00000000_7FFFFFFF);

        for (int t = 0; t < 15; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Reset while a load waits for data; a late rvalid must be ignored
        @(negedge clk);
        dec_valid = 1'b1; op_flags = 11'h040; rd = 5'd7; imm = 12'h000; rs1_val = 64'h6000;
        @(posedge clk);
        @(negedge clk);
        dec_valid = 1'b0;
        check("rst_mid req_valid", {63'h0, mem_req_valid}, 64'h1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rst_mid in_wait", {62'h0, dec_ready, mem_req_valid}, 64'h0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
        saw_wb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (wb_valid || exc_valid) saw_wb = 1'b1;
        end
        check("rst_mid no_wb", {63'h0, saw_wb}, 64'h0);
        check("rst_mid idle", {63'h0, dec_ready}, 64'h1);

        for (int k = 0; k < 150; k++) begin
            vec_t v;
            int r, a, b;
            logic [2:0] want;
            r = $urandom_range(0, 19);
            a = $urandom_range(0, 10);
            if (r == 0) begin
                v.flags = 11'h000;
            end else if (r == 1) begin
                b = (a + 1 + $urandom_range(0, 9)) % 11;
                v.flags = 11'(1 << a) | 11'(1 << b);
            end else begin
                v.flags = 11'(1 << a);
            end
            v.rd = 5'($urandom); v.imm = 12'($urandom);
            v.rs1 = {$urandom, $urandom}; v.rs2 = {$urandom, $urandom}; v.rdata = {$urandom, $urandom};
            v.rdy_dly = $urandom_range(0, 3); v.rv_dly = $urandom_range(0, 3);
            if (r >= 2 && $urandom_range(0, 3) != 0) begin
                want = 3'($urandom_range(0, 7)) & ~3'(nbytes(a) - 1);
                v.rs1[2:0] = want - v.imm[2:0];
            end
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
